// File: rtl/ula_pkg.sv
// Shared definitions for the ALU control unit: opcodes, FSM states,
// instruction field positions and the datapath width.
package ula_pkg;

  localparam int W = 16;

  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_ADD   = 3'b001;
  localparam logic [2:0] OP_ADDI  = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_SUBI  = 3'b100;
  localparam logic [2:0] OP_MUL   = 3'b101;
  localparam logic [2:0] OP_CLEAR = 3'b110;
  localparam logic [2:0] OP_NOP   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_WRITE  = 2'd3
  } state_t;

  localparam int OP_MSB    = 15;
  localparam int OP_LSB    = 13;
  localparam int RD_MSB    = 12;
  localparam int RD_LSB    = 10;
  localparam int RS1_MSB   = 9;
  localparam int RS1_LSB   = 7;
  localparam int RS2_MSB   = 6;
  localparam int RS2_LSB   = 4;
  localparam int IMM7_MSB  = 6;
  localparam int IMM10_MSB = 9;

endpackage

// File: rtl/ula.sv
// 16-bit signed ALU producing a 17-bit two's-complement result.
// param: 001/010 add, 011/100 subtract, 101 multiply (product truncated
// to W+1 bits), anything else yields zero.
module ula #(
  parameter int W = 16
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  input  logic        [2:0]   param,
  output logic signed [W:0]   s
);

  logic signed [2*W-1:0] prod;

  // Combinational operation select; add/sub are exact in W+1 bits.
  always_comb begin
    s    = '0;
    prod = a * b;
    case (param)
      3'b001, 3'b010: s = {a[W-1], a} + {b[W-1], b};
      3'b011, 3'b100: s = {a[W-1], a} - {b[W-1], b};
      3'b101:         s = prod[W:0];
      default:        s = '0;
    endcase
  end

endmodule

// File: rtl/unidade_controle_ula.sv
// Instruction-issue unit for the ALU: accepts one instruction at a time,
// fetches operands from an 8-entry register file, runs the ALU and writes
// the truncated result back. Four cycles per instruction, fixed latency.
module unidade_controle_ula
  import ula_pkg::*;
#(
  parameter int NREG = 8,
  parameter int W    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [15:0]   instr,
  output logic          done,
  output logic [W-1:0]  result,
  output logic          ovf,
  input  logic [2:0]    dbg_addr,
  output logic [W-1:0]  dbg_data
);

  state_t state, next_state;

  logic [15:0]        ir;
  logic signed [W-1:0] a_q, b_q;
  logic signed [W:0]   s, s_q;
  logic [W-1:0]       rf [NREG];
  logic [2:0]         param;

  logic [2:0] op, rd, rs1, rs2;
  logic [W-1:0] imm7_x, imm10_x;

  assign op      = ir[OP_MSB:OP_LSB];
  assign rd      = ir[RD_MSB:RD_LSB];
  assign rs1     = ir[RS1_MSB:RS1_LSB];
  assign rs2     = ir[RS2_MSB:RS2_LSB];
  assign imm7_x  = {{(W-7){ir[IMM7_MSB]}}, ir[IMM7_MSB:0]};
  assign imm10_x = {{(W-10){ir[IMM10_MSB]}}, ir[IMM10_MSB:0]};

  assign dbg_data = rf[dbg_addr];

  // ALU op code: arithmetic opcodes pass straight through, others idle the ALU.
  always_comb begin
    param = 3'b000;
    if (op == OP_ADD || op == OP_ADDI || op == OP_SUB ||
        op == OP_SUBI || op == OP_MUL)
      param = op;
  end

  ula #(.W(W)) u_ula (
    .a     (a_q),
    .b     (b_q),
    .param (param),
    .s     (s)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // Next-state and handshake outputs; the sequence is fixed, only IDLE waits.
  always_comb begin
    next_state  = state;
    instr_ready = 1'b0;
    done        = 1'b0;
    case (state)
      ST_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) next_state = ST_DECODE;
      end
      ST_DECODE: next_state = ST_EXEC;
      ST_EXEC:   next_state = ST_WRITE;
      ST_WRITE: begin
        done       = 1'b1;
        next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Datapath: IR capture, operand fetch, ALU result register and write-back.
  // Operands are latched in DECODE, so rd may alias rs1/rs2 safely.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir     <= '0;
      a_q    <= '0;
      b_q    <= '0;
      s_q    <= '0;
      result <= '0;
      ovf    <= 1'b0;
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (instr_valid) ir <= instr;
        end
        ST_DECODE: begin
          a_q <= rf[rs1];
          if (op == OP_ADDI || op == OP_SUBI) b_q <= imm7_x;
          else                                b_q <= rf[rs2];
        end
        ST_EXEC: begin
          s_q <= s;
        end
        ST_WRITE: begin
          case (op)
            OP_LOAD: begin
              rf[rd] <= imm10_x;
              result <= imm10_x;
              ovf    <= 1'b0;
            end
            OP_CLEAR: begin
              for (int i = 0; i < NREG; i++) rf[i] <= '0;
              result <= '0;
              ovf    <= 1'b0;
            end
            OP_NOP: begin
              result <= '0;
              ovf    <= 1'b0;
            end
            default: begin
              rf[rd] <= s_q[W-1:0];
              result <= s_q[W-1:0];
              ovf    <= s_q[W] ^ s_q[W-1];
            end
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/unidade_controle_ula.md
# unidade_controle_ula

Sequential instruction-issue unit that feeds the team's 16-bit ALU (`ula`). It accepts one 16-bit instruction at a time over a valid/ready handshake and decodes it into the ALU's 3-bit `param` code. It fetches signed operands from an internal 8×16 register file, registers the ALU's 17-bit result and writes the truncated 16-bit value back. It sits between the instruction source (switches/ROM sequencer) and the ALU, and exposes a debug read port for display and verification.

## Interface
Parameters:
- `NREG`, 8: register-file depth; register index width is 3 bits.
- `W`, 16: data width; the ALU result is `W+1` bits.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `instr_valid`  in  1  source presents an instruction.
- `instr_ready`  out  1  high only in IDLE.
- `instr`  in  16  instruction word.
- `done`  out  1  one-cycle pulse when an instruction retires.
- `result`  out  16  value written by the last retired instruction.
- `ovf`  out  1  overflow of the last retired instruction.
- `dbg_addr`  in  3  debug register select.
- `dbg_data`  out  16  combinational read of `rf[dbg_addr]`.

## Operation
- Instruction fields: `op=instr[15:13]`, `rd=[12:10]`, `rs1=[9:7]`, `rs2=[6:4]`, `imm7=[6:0]`, `imm10=[9:0]`. Immediates are sign-extended to 16 bits.
- Opcodes:
  - 000 LOAD: `rd ← sext(imm10)`.
  - 001 ADD: `rd ← rs1 + rs2`.
  - 010 ADDI: `rd ← rs1 + sext(imm7)`.
  - 011 SUB: `rd ← rs1 - rs2`.
  - 100 SUBI: `rd ← rs1 - sext(imm7)`.
  - 101 MUL: `rd ← rs1 * rs2`.
  - 110 CLEAR: all registers ← 0.
  - 111 NOP: no write.
- ALU ops 001–101 pass `op` unchanged as `param`. For LOAD, CLEAR and NOP, `param` is driven to 3'b000.
- Arithmetic rules:
  - The ALU output is the 17-bit two's-complement result.
  - Write-back is `S[15:0]`.
  - `ovf = S[16] ^ S[15]` for ALU ops. For MUL this flags only the 17-bit truncated product.
  - `ovf = 0` for LOAD, CLEAR and NOP.
- `result`:
  - ALU ops and LOAD: the written value.
  - CLEAR and NOP: 0.
- All registers, including r0, are writable. `rd` may equal `rs1` or `rs2`; operands are captured before write-back.
- FSM states:
  - IDLE: `instr_ready=1`. On `instr_valid && instr_ready`, latch `instr` into IR and go to DECODE.
  - DECODE: capture operands `A_q=rf[rs1]` and `B_q=rf[rs2]`, or `B_q=sext(imm7)` for ADDI/SUBI. Go to EXEC.
  - EXEC: `ula` computes from `A_q`, `B_q` and `param`. Register `S` into `S_q`. Go to WRITE.
  - WRITE: perform write-back or CLEAR, update `result` and `ovf`, pulse `done`. Go to IDLE.
- `instr_valid` outside IDLE is ignored. The instruction is neither latched nor queued.
- Reset (any state, including mid-instruction):
  - State ← IDLE; the in-flight instruction is discarded with no write and no `done`.
  - Outputs: `instr_ready=1`, `done=0`, `result=0`, `ovf=0`.
  - All `rf` entries and IR, `A_q`, `B_q`, `S_q` cleared to 0.

## Timing
- The handshake edge is E0.
- Edges E1–E3:
  - DECODE occupies the cycle after E0 and ends at E1.
  - EXEC ends at E2.
  - WRITE state ends at E3; `done` is high for the one cycle ending at E3.
  - Register write, `result` and `ovf` take effect at E3.
- The written value is visible on `dbg_data` in the cycle after E3.
- `instr_ready` is low from E0 until E3 and high again after E3. Maximum throughput is one instruction per 4 cycles.
- Latency is identical for all opcodes.
- `dbg_data` is combinational and reflects the register file as of the last edge.

## Structure
- Shared package `ula_pkg`:
  - opcode constants (`OP_LOAD` … `OP_NOP`);
  - FSM state encoding (IDLE, DECODE, EXEC, WRITE);
  - instruction field bit positions;
  - `W`.
- One sub-module: the existing `ula`, instantiated unchanged and driven from `A_q`, `B_q` and `param`. The register file and FSM stay in this module.

## Test plan
- **Reset values:** assert `rst` for 2 cycles → `instr_ready=1`, `done=0`, `result=0`, `ovf=0`, `dbg_data=0` for every address 0–7.
- **Load, add, subtract-immediate:**
  - LOAD r1,5 and LOAD r2,-3 → each done with `result` 0x0005 / 0xFFFD.
  - ADD r3,r1,r2 → `result=2`, `ovf=0`.
  - SUBI r4,r1,-64 → `result=69`.
  - Check `done` fires exactly 3 edges after each accept edge.
- **Multiply overflow:** LOAD r5,300; MUL r5,r5,r5 → `S=0x15F90`, `rf[5]=0x5F90`, `ovf=1`.
- **Add overflow:** following the previous scenario, ADD r6,r5,r5 → `rf[6]=0xBF20`, `ovf=1`.
- **Backpressure:** hold `instr_valid=1` with two distinct instructions back-to-back → `instr_ready` low for 3 cycles after the first accept; the second instruction is accepted at the first edge where `instr_ready=1` (4 edges after the first); no instruction is dropped or duplicated.
- **Reset mid-op, CLEAR, NOP:**
  - Assert `rst` during EXEC of ADD r7,r1,r2 → no `done`, `rf[7]=0`, `instr_ready=1` after release.
  - Separately, CLEAR → all `dbg_data=0`, `result=0`.
  - NOP → `done` pulses and no register changes.
